mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit that produces the HI and LO registers feeding the CPU's MEMtoReg mux (mfhi/mflo paths).
- Operands come from the A/B register outputs.
- The control unit starts an operation with a one-cycle pulse and stalls on busy until done.
- Implementation: radix-2 shift-add multiply and restoring divide, one iteration per clock.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start_mult  input  1  one-cycle pulse; begin signed multiply of op_a * op_b.
- start_div  input  1  one-cycle pulse; begin signed divide op_a / op_b.
- op_a  input  WIDTH  multiplicand / dividend (A register).
- op_b  input  WIDTH  multiplier / divisor (B register).
- hi  output  WIDTH  HI register: product[63:32] or remainder.
- lo  output  WIDTH  LO register: product[31:0] or quotient.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when hi/lo are updated or an operation aborts.
- div_zero  output  1  one-cycle pulse with done when divisor is 0 (exception request to ctrl unit).

Behaviour:
- Reset (async, any state): hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
- States: IDLE, MULT, DIV, FINISH.
- IDLE, edge E0 with a start pulse:
  - Operands are latched; op_a/op_b may change afterwards.
  - Both starts high: multiply wins, divide is ignored.
  - start_mult: latch magnitudes plus result sign (a[31]^b[31]), counter=0, go to MULT.
  - start_div with op_b != 0: latch magnitudes, quotient sign (a[31]^b[31]) and remainder sign (a[31]), go to DIV.
  - start_div with op_b == 0: go to FINISH with the div_zero flag set; hi/lo unchanged; no iterations.
- MULT: one shift-add step per edge on a 2*WIDTH accumulator. After WIDTH steps (edge E32), apply sign to the 64-bit magnitude, write hi/lo, go to FINISH.
- DIV: one restoring step per edge (shift remainder, trial subtract, set quotient bit). After WIDTH steps (edge E32):
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Write lo=quotient, hi=remainder, go to FINISH.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0 (wrap, no flag).
- FINISH: done=1 for exactly one cycle (div_zero=1 too if flagged), then IDLE on the next edge.
- busy is high in MULT/DIV only: 32 cycles for mul/div, 0 cycles for divide-by-zero.
- Latency, start edge to done cycle: 33 cycles normally, 1 cycle for divide-by-zero.
- Start pulses while not in IDLE, including FINISH, are ignored; no queuing.
- hi/lo hold their values between operations; they change only at the final iteration edge or on reset.
- Reset mid-operation aborts immediately; no done pulse, outputs go to reset values.

Optional Feature:
- Macro MULT_DIV_UNSIGNED_EN.
- When defined: adds input port op_unsigned (1 bit), sampled with the start pulse.
  - If 1: operands are treated as unsigned magnitudes, sign fix-up is skipped (multu/divu).
  - Latency, divide-by-zero handling and all handshakes are identical.
- When undefined: the port is absent and all operations are signed.

Test Plan:
- start_mult, op_a=7, op_b=0xFFFFFFFD (-3) -> busy 32 cycles, done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- start_mult, op_a=op_b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- start_div, op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Preload hi/lo via a multiply, then start_div with op_b=0 -> done and div_zero high one cycle after the start edge, busy never high, hi/lo unchanged.
- Start a divide, pulse start_mult at cycle 10 -> ignored, divide result correct; assert reset at cycle 20 -> hi=lo=0, busy=0 immediately, no done pulse.
- With MULT_DIV_UNSIGNED_EN: op_unsigned=1, start_mult 0xFFFFFFFF * 2 -> hi=0x00000001, lo=0xFFFFFFFE; start_div 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0xF.

Source files
------------

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Multicycle signed multiply / divide producing the HI and LO
//            registers; radix-2 shift-add multiply, restoring divide.
//            Optional macro MULT_DIV_UNSIGNED_EN adds op_unsigned (multu/divu).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic             op_unsigned,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dz;

    logic                 w_unsigned;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_b_zero;
    logic                 w_last;

`ifdef MULT_DIV_UNSIGNED_EN
    assign w_unsigned = op_unsigned;
`else
    assign w_unsigned = 1'b0;
`endif

    assign w_a_neg  = op_a[WIDTH-1] & ~w_unsigned;
    assign w_b_neg  = op_b[WIDTH-1] & ~w_unsigned;
    assign w_a_mag  = w_a_neg ? (~op_a + 1'b1) : op_a;
    assign w_b_mag  = w_b_neg ? (~op_b + 1'b1) : op_b;
    assign w_b_zero = (op_b == '0);
    assign w_last   = (r_cnt == c_LAST);

    // Multiply: accumulator is {partial product, remaining multiplier bits}.
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg_q ? (~w_mul_next + 1'b1) : w_mul_next;

    // Divide: accumulator is {partial remainder, dividend bits becoming quotient}.
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_trial;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_rem;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge    = ~w_div_trial[WIDTH];
    assign w_div_rem   = w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
    assign w_quo = r_neg_q ? (~w_div_next[WIDTH-1:0] + 1'b1) : w_div_next[WIDTH-1:0];
    assign w_rem = r_neg_r ? (~w_div_next[2*WIDTH-1:WIDTH] + 1'b1)
                           : w_div_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        div_zero = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_mult) begin
                    w_next = S_MULT;
                end else if (start_div) begin
                    w_next = w_b_zero ? S_FINISH : S_DIV;
                end
            end
            S_MULT, S_DIV: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                done     = 1'b1;
                div_zero = r_dz;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dz <= ~start_mult & start_div & w_b_zero;
                    if (start_mult) begin
                        r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                        r_opnd  <= w_a_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= 1'b0;
                        r_cnt   <= '0;
                    end else if (start_div && !w_b_zero) begin
                        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_opnd  <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= '0;
                    end
                end
                S_MULT: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        hi <= w_prod[2*WIDTH-1:WIDTH];
                        lo <= w_prod[WIDTH-1:0];
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        hi <= w_rem;
                        lo <= w_quo;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Directed self-checking bench for mult_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_unsigned;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
`ifdef MULT_DIV_UNSIGNED_EN
        .op_unsigned(op_unsigned),
`endif
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    // Drives one start pulse, scrambles operands after the start edge, and
    // returns the cycle index of done (0 on timeout) and the busy-cycle count.
    // Returns positioned #1 after the edge that begins the done cycle.
    task automatic run_op(input logic m, input logic d, input logic u,
                          input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int bc);
        @(negedge clock);
        start_mult = m; start_div = d; op_unsigned = u; op_a = a; op_b = b;
        @(posedge clock); #1;
        start_mult = 0; start_div = 0; op_a = $urandom; op_b = $urandom;
        cyc = 0; bc = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) bc++;
            if (done) begin cyc = k; break; end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1; start_mult = 0; start_div = 0; op_a = 0; op_b = 0; op_unsigned = 0;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b, want all zero",
                     hi, lo, busy, done, div_zero);
        end
        @(negedge clock); reset = 0;
    endtask

    task automatic test_op(input string name, input logic m, input logic d, input logic u,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc, bc;
        run_op(m, d, u, a, b, cyc, bc);
        vectors++;
        if (cyc !== 33 || bc !== 32) begin
            miscompares++;
            $display("FAIL %s_timing: got done_cycle=%0d busy_cycles=%0d, want 33/32", name, cyc, bc);
        end
        vectors++;
        if (hi !== exp_hi || lo !== exp_lo || div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_result: got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=0",
                     name, hi, lo, div_zero, exp_hi, exp_lo);
        end
        @(posedge clock); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done_pulse: got done=%b busy=%b after done cycle, want 0/0", name, done, busy);
        end
    endtask

    task automatic test_mult();
        test_op("mul_7xm3", 1, 0, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        test_op("mul_min_sq", 1, 0, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        test_op("mul_both_start", 1, 1, 0, 32'd12, 32'd10, 32'h00000000, 32'd120);
    endtask

    task automatic test_div();
        test_op("div_m7_2", 0, 1, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_op("div_100_m7", 0, 1, 0, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
        test_op("div_min_m1", 0, 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    endtask

    task automatic test_div_zero();
        int cyc, bc;
        test_op("preload", 1, 0, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op(0, 1, 0, 32'd55, 32'd0, cyc, bc);
        vectors++;
        if (cyc !== 1 || bc !== 0 || div_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL divz_flag: got done_cycle=%0d busy_cycles=%0d dz=%b, want 1/0/1", cyc, bc, div_zero);
        end
        vectors++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            miscompares++;
            $display("FAIL divz_hold: got hi=%h lo=%h, want hi=ffffffff lo=ffffffeb", hi, lo);
        end
        @(posedge clock); #1;
        vectors++;
        if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL divz_pulse: got done=%b dz=%b busy=%b, want 0/0/0", done, div_zero, busy);
        end
    endtask

    task automatic test_ignore_starts();
        int k;
        logic seen;
        // Start a divide; a start_mult at cycle 10 must be ignored.
        @(negedge clock);
        start_div = 1; op_a = 32'd1000; op_b = 32'd7;
        @(posedge clock); #1;
        start_div = 0;
        k = 1; seen = 0;
        while (k <= 40 && !seen) begin
            if (k == 10) begin start_mult = 1; op_a = 32'd3; op_b = 32'd3; end
            else start_mult = 0;
            if (done) seen = 1;
            else begin @(posedge clock); #1; k++; end
        end
        start_mult = 0;
        vectors++;
        if (k !== 33 || hi !== 32'd6 || lo !== 32'd142) begin
            miscompares++;
            $display("FAIL ignore_busy: got done_cycle=%0d hi=%h lo=%h, want 33 hi=6 lo=8e", k, hi, lo);
        end
        // Start pulse during FINISH is also ignored.
        start_mult = 1; op_a = 32'd5; op_b = 32'd5;
        @(posedge clock); #1;
        start_mult = 0;
        @(posedge clock); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_finish: got busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    task automatic test_abort();
        logic saw_done;
        @(negedge clock);
        start_div = 1; op_a = 32'd1000; op_b = 32'd7;
        @(posedge clock); #1;
        start_div = 0;
        saw_done = 0;
        for (int k = 1; k < 20; k++) begin
            if (done) saw_done = 1;
            @(posedge clock); #1;
        end
        reset = 1;
        #1;
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_clear: got hi=%h lo=%h busy=%b, want 0/0/0", hi, lo, busy);
        end
        @(negedge clock); reset = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (done || busy) saw_done = 1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: got activity=%b, want 0", saw_done);
        end
    endtask

`ifdef MULT_DIV_UNSIGNED_EN
    task automatic test_unsigned();
        test_op("multu", 1, 0, 1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
        test_op("divu", 0, 1, 1, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF);
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignore_starts();
        test_abort();
`ifdef MULT_DIV_UNSIGNED_EN
        test_unsigned();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
